// File: rtl/l2_sqrt.sv
// Digit-by-digit integer square root, two operand bits per cycle.
// The upstream overflow tag travels with each operand and saturates the result.
module l2_sqrt #(
  parameter int WIDTH_IN  = 20,
  parameter int WIDTH_OUT = WIDTH_IN / 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_IN-1:0]  f_in,
  input  logic                 valid_in,
  input  logic                 ovf_in,
  output logic                 busy,
  output logic [WIDTH_OUT-1:0] root,
  output logic [WIDTH_OUT:0]   rem,
  output logic                 ovf_out,
  output logic                 valid_out,
  output logic                 drop
);

  localparam int RW = WIDTH_OUT + 2;
  localparam int CW = $clog2(WIDTH_OUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH_IN-1:0]  op_q, op_d;
  logic [RW-1:0]        r_q, r_d;
  logic [WIDTH_OUT-1:0] q_q, q_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [WIDTH_OUT-1:0] root_q, root_d;
  logic [WIDTH_OUT:0]   rem_q, rem_d;
  logic                 ovf_out_q, ovf_out_d;
  logic                 valid_out_q, valid_out_d;
  logic                 drop_q, drop_d;
  logic                 busy_q, busy_d;

  logic                 accept_s;
  logic [RW-1:0]        r_sh_s;
  logic [RW-1:0]        trial_s;
  logic [RW-1:0]        r_next_s;
  logic [WIDTH_OUT-1:0] q_next_s;

  // One root digit per cycle; the top two remainder bits are always zero before the shift.
  always_comb begin
    accept_s = valid_in && (state_q != CALC);
    r_sh_s   = {r_q[RW-3:0], op_q[WIDTH_IN-1 -: 2]};
    trial_s  = {q_q, 2'b01};
    if (r_sh_s >= trial_s) begin
      r_next_s = r_sh_s - trial_s;
      q_next_s = {q_q[WIDTH_OUT-2:0], 1'b1};
    end else begin
      r_next_s = r_sh_s;
      q_next_s = {q_q[WIDTH_OUT-2:0], 1'b0};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    r_d         = r_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    root_d      = root_q;
    rem_d       = rem_q;
    ovf_out_d   = ovf_out_q;
    valid_out_d = 1'b0;
    drop_d      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          op_d    = f_in;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = CW'(WIDTH_OUT - 1);
          ovf_d   = ovf_in;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        drop_d = valid_in;
        r_d    = r_next_s;
        q_d    = q_next_s;
        op_d   = {op_q[WIDTH_IN-3:0], 2'b00};
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d     = DONE;
          valid_out_d = 1'b1;
          if (ovf_q) begin
            root_d    = '1;
            rem_d     = '0;
            ovf_out_d = 1'b1;
          end else begin
            root_d    = q_next_s;
            rem_d     = r_next_s[WIDTH_OUT:0];
            ovf_out_d = 1'b0;
          end
        end else begin
          state_d = CALC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CALC);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      r_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      root_q      <= '0;
      rem_q       <= '0;
      ovf_out_q   <= 1'b0;
      valid_out_q <= 1'b0;
      drop_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      r_q         <= r_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      root_q      <= root_d;
      rem_q       <= rem_d;
      ovf_out_q   <= ovf_out_d;
      valid_out_q <= valid_out_d;
      drop_q      <= drop_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign root      = root_q;
  assign rem       = rem_q;
  assign ovf_out   = ovf_out_q;
  assign valid_out = valid_out_q;
  assign drop      = drop_q;

endmodule

// File: tb/tb_l2_sqrt.sv
// Self-checking bench for l2_sqrt: directed cases, drop/back-to-back, async reset
// and a random sweep checked against the square-root rule and a timing model.
module tb_l2_sqrt;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] f_in;
  logic        valid_in;
  logic        ovf_in;
  logic        busy;
  logic [9:0]  root;
  logic [10:0] rem;
  logic        ovf_out;
  logic        valid_out;
  logic        drop;

  int checks = 0;
  int errors = 0;

  l2_sqrt dut (
    .clk(clk), .reset(reset), .f_in(f_in), .valid_in(valid_in), .ovf_in(ovf_in),
    .busy(busy), .root(root), .rem(rem), .ovf_out(ovf_out),
    .valid_out(valid_out), .drop(drop)
  );

  always #5 clk = ~clk;

  // Pulse valid_in for one cycle and wait (bounded) for the result.
  task automatic do_op(input logic [19:0] f, input logic o, output int lat, output int busy_cnt);
    @(posedge clk); #1;
    f_in = f; ovf_in = o; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; ovf_in = 1'b0;
    lat = 1; busy_cnt = 0;
    while (valid_out !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; ovf_in = 1'b0; f_in = 20'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, root, rem, ovf_out, valid_out, drop} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b root=%0d rem=%0d ovf=%b vo=%b drop=%b, required all 0",
               busy, root, rem, ovf_out, valid_out, drop);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [19:0] fv [5] = '{20'd144, 20'd200, 20'd0, 20'd1, 20'd1048575};
    int          er [5] = '{12, 14, 0, 1, 1023};
    int          em [5] = '{0, 4, 0, 0, 2046};
    int lat, bc;
    for (int i = 0; i < 5; i++) begin
      do_op(fv[i], 1'b0, lat, bc);
      checks++;
      if (lat != 11 || bc != 10) begin
        errors++;
        $display("FAIL basic_timing f=%0d: got latency=%0d busy_cycles=%0d, required 11 and 10", fv[i], lat, bc);
      end
      checks++;
      if (valid_out !== 1'b1 || root !== 10'(er[i]) || rem !== 11'(em[i]) || ovf_out !== 1'b0) begin
        errors++;
        $display("FAIL basic_result f=%0d: got vo=%b root=%0d rem=%0d ovf=%b, required 1 %0d %0d 0",
                 fv[i], valid_out, root, rem, ovf_out, er[i], em[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (valid_out !== 1'b0 || root !== 10'd1023 || rem !== 11'd2046) begin
      errors++;
      $display("FAIL basic_hold: got vo=%b root=%0d rem=%0d, required 0 1023 2046", valid_out, root, rem);
    end
  endtask

  task automatic test_saturate();
    int lat, bc;
    do_op(20'd500, 1'b1, lat, bc);
    checks++;
    if (lat != 11 || root !== 10'd1023 || rem !== 11'd0 || ovf_out !== 1'b1) begin
      errors++;
      $display("FAIL saturate: got lat=%0d root=%0d rem=%0d ovf=%b, required 11 1023 0 1", lat, root, rem, ovf_out);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(posedge clk); #1;
    f_in = 20'd81; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    f_in = 20'd9; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if (drop !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: got drop=%b busy=%b, required 1 1", drop, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_single: got drop=%b, required 0", drop);
    end
    lat = 5;
    while (valid_out !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 11 || root !== 10'd9 || rem !== 11'd0 || ovf_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d root=%0d rem=%0d ovf=%b, required 11 9 0 0", lat, root, rem, ovf_out);
    end
    f_in = 20'd49; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    checks++;
    if (drop !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: got drop=%b busy=%b, required 0 1", drop, busy);
    end
    lat = 1;
    while (valid_out !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 11 || root !== 10'd7 || rem !== 11'd0) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d root=%0d rem=%0d, required 11 7 0", lat, root, rem);
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc, seen;
    @(posedge clk); #1;
    f_in = 20'd400; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, root, rem, ovf_out, valid_out, drop} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b root=%0d rem=%0d ovf=%b vo=%b drop=%b, required all 0",
               busy, root, rem, ovf_out, valid_out, drop);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abandon: got %0d cycles with valid_out/busy, required 0", seen);
    end
    do_op(20'd400, 1'b0, lat, bc);
    checks++;
    if (lat != 11 || root !== 10'd20 || rem !== 11'd0) begin
      errors++;
      $display("FAIL reset_recover: got lat=%0d root=%0d rem=%0d, required 11 20 0", lat, root, rem);
    end
  endtask

  task automatic test_random_sweep();
    int          cyc = 0;
    int          pend_done = -1;
    longint      pend_f = 0;
    logic        pend_ovf = 1'b0;
    int          sent = 0;
    int          model_drops = 0;
    int          seen_drops = 0;
    logic        exp_drop = 1'b0;
    logic        vin;
    logic [19:0] fv;
    logic        ov;
    longint      r;
    @(posedge clk); #1;
    while (sent < 1000 && cyc < 20000) begin
      vin = ($urandom_range(0, 3) == 0);
      fv  = 20'($urandom_range(0, 20'hFFFFF));
      ov  = ($urandom_range(0, 7) == 0);
      f_in = fv; ovf_in = ov; valid_in = vin;
      exp_drop = 1'b0;
      if (vin) begin
        sent++;
        if (pend_done <= cyc) begin
          pend_done = cyc + 11;
          pend_f    = longint'(fv);
          pend_ovf  = ov;
        end else begin
          model_drops++;
          exp_drop = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      valid_in = 1'b0;
      if (drop === 1'b1) seen_drops++;
      checks++;
      if (valid_out !== (pend_done == cyc) || busy !== (pend_done > cyc) || drop !== exp_drop) begin
        errors++;
        if (errors < 20)
          $display("FAIL sweep_ctrl cyc=%0d: got vo=%b busy=%b drop=%b, required %b %b %b",
                   cyc, valid_out, busy, drop, pend_done == cyc, pend_done > cyc, exp_drop);
      end
      if (pend_done == cyc) begin
        r = longint'(root);
        checks++;
        if (pend_ovf) begin
          if (root !== 10'd1023 || rem !== 11'd0 || ovf_out !== 1'b1) begin
            errors++;
            if (errors < 20)
              $display("FAIL sweep_sat f=%0d: got root=%0d rem=%0d ovf=%b, required 1023 0 1", pend_f, root, rem, ovf_out);
          end
        end else if (!(r * r <= pend_f && (r + 1) * (r + 1) > pend_f) ||
                     longint'(rem) != pend_f - r * r || ovf_out !== 1'b0) begin
          errors++;
          if (errors < 20)
            $display("FAIL sweep_root f=%0d: got root=%0d rem=%0d ovf=%b, required floor-sqrt, rem=%0d, ovf 0",
                     pend_f, root, rem, ovf_out, pend_f - r * r);
        end
      end
    end
    repeat (12) begin
      @(posedge clk); #1;
      cyc++;
      if (pend_done == cyc) begin
        checks++;
        if (valid_out !== 1'b1) begin
          errors++;
          $display("FAIL sweep_tail: got valid_out=%b, required 1", valid_out);
        end
      end
    end
    checks++;
    if (sent != 1000 || seen_drops != model_drops) begin
      errors++;
      $display("FAIL sweep_drops: got sent=%0d drop pulses=%0d, required 1000 and %0d", sent, seen_drops, model_drops);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
